uart_tx: RTL and testbench

UART serial transmitter: the transmit-side counterpart of the receiver's start-bit detection path. It accepts one parallel data word per valid/ready handshake and serialises it as an asynchronous frame: start bit low, data LSB first, optional parity, then stop bit(s) high. Bit timing comes from an internal clock-divider counter. It sits between the host-side byte source and the TX pin; the line idles high.

---
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Purpose: host-side handshake and serial-line bundle for the UART transmitter.
// Latency: none; wiring only.
// Backpressure: tx_ready from the slave gates acceptance of tx_data/tx_valid.
// Signals: tx_data/tx_valid (host -> tx), tx_ready (tx -> host),
//          tx_out serial line, tx_busy frame-in-progress, tx_done end-of-frame pulse.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_out;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_out, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// Purpose: UART serialiser: start bit, DATA_BITS LSB first, optional parity, stop bit(s).
// Latency: handshake at edge N drives the start bit from cycle N+1; frame ends at N+F.
// Backpressure: tx_ready high only in IDLE; tx_valid is ignored while a frame is in flight.
// Ports: clk, rst_n (synchronous, active-low); bus = uart_tx_if slave
//        (tx_data, tx_valid in; tx_ready, tx_out, tx_busy, tx_done out).
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic            ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [3:0]           r_idx, w_idx_nxt;     // data bit index, reused as stop bit index
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_tx_out, r_tx_busy, r_tx_done;
  logic                 w_out_nxt, w_busy_nxt, w_done_nxt;
  logic                 w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (bus.tx_valid) begin
          w_shift_nxt = bus.tx_data;
          w_state_nxt = START;
        end
      end
      START: begin
        // The shift register still holds the untouched latched word here,
        // so parity is taken from it before any shifting starts.
        w_par_nxt = (^r_shift) ^ ODD;
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_idx == DATA_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      PARITY: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_wrap) begin
          w_cnt_nxt = '0;
          if (r_idx == STOP_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the next-cycle view.
    w_out_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_out_nxt = 1'b0;
      DATA:    w_out_nxt = w_shift_nxt[0];
      PARITY:  w_out_nxt = w_par_nxt;
      default: w_out_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == STOP) && (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == STOP_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx_out  <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
      r_tx_out  <= w_out_nxt;
      r_tx_busy <= w_busy_nxt;
      r_tx_done <= w_done_nxt;
    end
  end

  assign bus.tx_ready = (r_state == IDLE);
  assign bus.tx_out   = r_tx_out;
  assign bus.tx_busy  = r_tx_busy;
  assign bus.tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Purpose: self-checking bench for uart_tx (8N1, 8E1, 8O1 at 4 clocks per bit).
// Latency: a frame model predicts every output cycle from the accepting edge onward.
// Backpressure: the host holds tx_valid until tx_ready, as a real byte source must.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int C = 4;   // clocks per bit for every instance

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [3];
  logic [7:0] data  [3];
  logic       ready [3];
  logic       out   [3];
  logic       busy  [3];
  logic       done  [3];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Expected {tx_out, tx_busy, tx_done} per upcoming cycle; empty means idle.
  logic [2:0] mq [3][$];

  logic out_log   [3][4096];
  logic busy_log  [3][4096];
  logic done_log  [3][4096];
  logic ready_log [3][4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();

  assign if0.tx_valid = valid[0];
  assign if0.tx_data  = data[0];
  assign ready[0]     = if0.tx_ready;
  assign out[0]       = if0.tx_out;
  assign busy[0]      = if0.tx_busy;
  assign done[0]      = if0.tx_done;
  assign if1.tx_valid = valid[1];
  assign if1.tx_data  = data[1];
  assign ready[1]     = if1.tx_ready;
  assign out[1]       = if1.tx_out;
  assign busy[1]      = if1.tx_busy;
  assign done[1]      = if1.tx_done;
  assign if2.tx_valid = valid[2];
  assign if2.tx_data  = data[2];
  assign ready[2]     = if2.tx_ready;
  assign out[2]       = if2.tx_out;
  assign busy[2]      = if2.tx_busy;
  assign done[2]      = if2.tx_done;

  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  // Frame as a list of line bits; each bit lasts C cycles, done on the very last.
  task automatic push_frame(input int d, input logic [7:0] b);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (d != 0) bits.push_back((^b) ^ (d == 2));
    bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++)
      for (int c = 0; c < C; c++)
        mq[d].push_back({bits[k], 1'b1, (k == bits.size() - 1) && (c == C - 1)});
  endtask

  always @(negedge clk) begin : model
    logic [2:0] e;
    logic       er;
    for (int d = 0; d < 3; d++) begin
      er = (mq[d].size() == 0);
      e  = er ? 3'b100 : mq[d].pop_front();
      if (cyc < 4096) begin
        out_log[d][cyc]   = out[d];
        busy_log[d][cyc]  = busy[d];
        done_log[d][cyc]  = done[d];
        ready_log[d][cyc] = ready[d];
      end
      if (armed) begin
        chk($sformatf("dut%0d cyc%0d out_busy_done", d, cyc), {29'd0, out[d], busy[d], done[d]}, {29'd0, e});
        chk($sformatf("dut%0d cyc%0d ready", d, cyc), {31'd0, ready[d]}, {31'd0, er});
      end
      if (rst_n === 1'b0) mq[d].delete();
      else if (armed && er && valid[d] === 1'b1) push_frame(d, data[d]);
    end
    if (rst_n === 1'b0) armed = 1'b1;
  end

  function automatic logic [3:0] cells(input int d, input int s);
    return {out_log[d][s+3], out_log[d][s+2], out_log[d][s+1], out_log[d][s]};
  endfunction

  function automatic logic [7:0] decode(input int d, input int n);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = out_log[d][n + 1 + C * (1 + i) + C / 2];
    return r;
  endfunction

  function automatic int count_done(input int d, input int a, input int b);
    int k = 0;
    for (int i = a; i <= b; i++) if (done_log[d][i] === 1'b1) k++;
    return k;
  endfunction

  // Returns n = the edge at which the word was accepted.
  task automatic send(input int d, input logic [7:0] b, input bit keep, output int n);
    @(posedge clk); #1;
    data[d]  = b;
    valid[d] = 1'b1;
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) begin
      chk("send_timeout", 32'd0, 32'd1);
      n = 0;
    end
    @(posedge clk); #1;
    if (!keep) valid[d] = 1'b0;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         n, n2, gap;
    logic [9:0] seq;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0;
      data[d]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values, then 50 idle cycles watched by the model.
    @(negedge clk);
    chk("rst_out", {31'd0, out[0]}, 32'd1);
    chk("rst_ready", {31'd0, ready[0]}, 32'd1);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_done", {31'd0, done[0]}, 32'd0);
    wait_cycles(50);
    chk("idle50_out", {31'd0, out[0]}, 32'd1);

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit.
    send(0, 8'hA5, 1'b0, n);
    wait_cycles(45);
    seq = 10'b1101001010;
    for (int i = 0; i < 10; i++)
      chk($sformatf("a5_bit%0d", i), {28'd0, cells(0, n + 1 + C * i)}, {28'd0, {4{seq[i]}}});
    chk("a5_busy_n1", {31'd0, busy_log[0][n+1]}, 32'd1);
    chk("a5_done_n39", {31'd0, done_log[0][n+39]}, 32'd0);
    chk("a5_done_n40", {31'd0, done_log[0][n+40]}, 32'd1);
    chk("a5_done_n41", {31'd0, done_log[0][n+41]}, 32'd0);
    chk("a5_ready_n40", {31'd0, ready_log[0][n+40]}, 32'd0);
    chk("a5_ready_n41", {31'd0, ready_log[0][n+41]}, 32'd1);
    chk("a5_busy_n41", {31'd0, busy_log[0][n+41]}, 32'd0);

    // Even parity of 0xA5 is 0, odd is 1; parity bit occupies N+37..N+40.
    send(1, 8'hA5, 1'b0, n);
    wait_cycles(50);
    chk("even_data", {24'd0, decode(1, n)}, 32'hA5);
    chk("even_par", {28'd0, cells(1, n + 37)}, 32'h0);
    chk("even_done_n40", {31'd0, done_log[1][n+40]}, 32'd0);
    chk("even_done_n44", {31'd0, done_log[1][n+44]}, 32'd1);
    send(2, 8'hA5, 1'b0, n);
    wait_cycles(50);
    chk("odd_par", {28'd0, cells(2, n + 37)}, 32'hF);
    chk("odd_done_n44", {31'd0, done_log[2][n+44]}, 32'd1);

    // Back-to-back 0x00 then 0xFF with tx_valid held high.
    send(0, 8'h00, 1'b1, n);
    send(0, 8'hFF, 1'b0, n2);
    wait_cycles(50);
    chk("b2b_second_edge", n2, n + 41);
    chk("b2b_second_start", {31'd0, out_log[0][n2+1]}, 32'd0);
    gap = 0;
    for (int k = n2; k > n && out_log[0][k] === 1'b1; k--) gap++;
    chk("b2b_gap", gap, 5);
    chk("b2b_data0", {24'd0, decode(0, n)}, 32'h00);
    chk("b2b_data1", {24'd0, decode(0, n2)}, 32'hFF);
    chk("b2b_dones", count_done(0, n + 1, n2 + 41), 2);

    // tx_valid toggling and tx_data changing mid-frame must have no effect.
    send(0, 8'h3C, 1'b0, n);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      valid[0] = i[0];
      data[0]  = 8'hC3;
    end
    valid[0] = 1'b0;
    wait_cycles(20);
    chk("busy_ign_data", {24'd0, decode(0, n)}, 32'h3C);
    chk("busy_ign_dones", count_done(0, n + 1, n + 50), 1);

    // Reset for one edge during data bit 3 (cycles N+17..N+20) of 0x96.
    send(0, 8'h96, 1'b0, n);
    wait_cycles(17);
    rst_n = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(30);
    chk("mid_rst_before", {31'd0, out_log[0][n+18]}, 32'd0);
    chk("mid_rst_out", {31'd0, out_log[0][n+19]}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy_log[0][n+19]}, 32'd0);
    chk("mid_rst_nodone", count_done(0, n + 1, n + 48), 0);
    send(0, 8'h55, 1'b0, n);
    wait_cycles(45);
    chk("post_rst_data", {24'd0, decode(0, n)}, 32'h55);
    chk("post_rst_done", {31'd0, done_log[0][n+40]}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
